// File: rtl/bht_sat_predictor_pkg.sv
// Shared types and helpers for the saturating-counter branch history table.
package bht_pkg;

    typedef enum logic {
        BHT_INIT,
        BHT_RUN
    } bht_state_e;

    localparam int BHT_DEPTH_DEF = 32;
    localparam int BHT_CTR_W_DEF = 2;

    // Saturating up/down counter step for a w-bit counter: clamps at 0 and 2**w-1.
    function automatic int unsigned ctr_next(input int unsigned ctr,
                                             input logic        taken,
                                             input int unsigned w);
        int unsigned max_v;
        max_v = (32'd1 << w) - 32'd1;
        if (taken) begin
            return (ctr >= max_v) ? max_v : ctr + 32'd1;
        end
        return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/bht_sat_predictor_if.sv
// Prediction / resolution bus of the branch history table.
// With BHT_GSHARE_EN defined the bus also carries the global history
// captured with a prediction (pred_ghr) and returned with its update (upd_ghr).
interface bht_sat_predictor_if #(
    parameter int IDX_W = 5,
    parameter int CTR_W = 2
`ifdef BHT_GSHARE_EN
    ,
    parameter int GHR_W = IDX_W
`endif
);
    logic             en;
    logic             rd_valid;
    logic [IDX_W-1:0] rd_idx;
    logic             pred_valid;
    logic             pred_taken;
    logic [CTR_W-1:0] pred_ctr;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             ready;
`ifdef BHT_GSHARE_EN
    logic [GHR_W-1:0] upd_ghr;
    logic [GHR_W-1:0] pred_ghr;

    modport master (
        output en, rd_valid, rd_idx, upd_valid, upd_idx, upd_taken, upd_ghr,
        input  pred_valid, pred_taken, pred_ctr, ready, pred_ghr
    );
    modport slave (
        input  en, rd_valid, rd_idx, upd_valid, upd_idx, upd_taken, upd_ghr,
        output pred_valid, pred_taken, pred_ctr, ready, pred_ghr
    );
`else
    modport master (
        output en, rd_valid, rd_idx, upd_valid, upd_idx, upd_taken,
        input  pred_valid, pred_taken, pred_ctr, ready
    );
    modport slave (
        input  en, rd_valid, rd_idx, upd_valid, upd_idx, upd_taken,
        output pred_valid, pred_taken, pred_ctr, ready
    );
`endif
endinterface

// File: rtl/bht_ctr_update.sv
// Combinational next-state of one CTR_W-bit saturating direction counter.
module bht_ctr_update
    import bht_pkg::*;
#(
    parameter int CTR_W = BHT_CTR_W_DEF
) (
    input  logic [CTR_W-1:0] ctr_i,
    input  logic             taken_i,
    output logic [CTR_W-1:0] ctr_o
);

    assign ctr_o = CTR_W'(ctr_next(32'(ctr_i), taken_i, CTR_W));

endmodule

// File: rtl/bht_sat_predictor.sv
// Branch history table of DEPTH saturating counters with registered prediction,
// single-cycle update, post-reset init sweep and read-during-write bypass.
// Optional gshare indexing is enabled by defining BHT_GSHARE_EN.
module bht_sat_predictor
    import bht_pkg::*;
#(
    parameter int DEPTH    = BHT_DEPTH_DEF,
    parameter int CTR_W    = BHT_CTR_W_DEF,
    parameter int INIT_CTR = 2**(CTR_W-1)-1
`ifdef BHT_GSHARE_EN
    ,
    parameter int GHR_W    = $clog2(DEPTH)
`endif
) (
    input  logic               clk,
    input  logic               rst,
    bht_sat_predictor_if.slave bus
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH-1);

    bht_state_e       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             ready_q;
    logic             pred_valid_q;
    logic             pred_taken_q;
    logic [CTR_W-1:0] pred_ctr_q;

    logic [CTR_W-1:0] table_q [DEPTH];

    logic             run;
    logic             rd_acc;
    logic             upd_acc;
    logic [IDX_W-1:0] rd_hidx;
    logic [IDX_W-1:0] upd_hidx;
    logic [CTR_W-1:0] upd_cur;
    logic [CTR_W-1:0] upd_next;
    logic [CTR_W-1:0] rd_ctr_d;

    logic             tbl_we;
    logic [IDX_W-1:0] tbl_waddr;
    logic [CTR_W-1:0] tbl_wdata;

`ifdef BHT_GSHARE_EN
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;
    logic [GHR_W-1:0] pred_ghr_q;

    // Hash both ports with global history; updates use the history seen at prediction time.
    assign rd_hidx  = bus.rd_idx ^ IDX_W'(ghr_q);
    assign upd_hidx = bus.upd_idx ^ IDX_W'(bus.upd_ghr);

    if (GHR_W == 1) begin : g_ghr1
        assign ghr_d = bus.upd_taken;
    end else begin : g_ghrn
        assign ghr_d = {ghr_q[GHR_W-2:0], bus.upd_taken};
    end

    assign bus.pred_ghr = pred_ghr_q;
`else
    assign rd_hidx  = bus.rd_idx;
    assign upd_hidx = bus.upd_idx;
`endif

    assign run     = (state_q == BHT_RUN);
    assign rd_acc  = run && bus.en && bus.rd_valid;
    assign upd_acc = run && bus.en && bus.upd_valid;
    assign ptr_d   = ptr_q + IDX_W'(1);

    assign upd_cur = table_q[upd_hidx];

    bht_ctr_update #(
        .CTR_W (CTR_W)
    ) u_ctr_upd (
        .ctr_i   (upd_cur),
        .taken_i (bus.upd_taken),
        .ctr_o   (upd_next)
    );

    // A read hitting the entry being updated this cycle sees the post-update value.
    assign rd_ctr_d = (upd_acc && (upd_hidx == rd_hidx)) ? upd_next : table_q[rd_hidx];

    // Select the single table write: sweep fill during INIT, counter update during RUN.
    always_comb begin
        tbl_we    = 1'b0;
        tbl_waddr = ptr_q;
        tbl_wdata = CTR_W'(INIT_CTR);
        if (!rst) begin
            if (state_q == BHT_INIT) begin
                tbl_we = 1'b1;
            end else if (upd_acc) begin
                tbl_we    = 1'b1;
                tbl_waddr = upd_hidx;
                tbl_wdata = upd_next;
            end
        end
    end

    // Counter storage; contents are defined by the init sweep, not by reset.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            table_q[tbl_waddr] <= tbl_wdata;
        end
    end

    // Control FSM with registered prediction outputs and ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BHT_INIT;
            ptr_q        <= '0;
            ready_q      <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_ctr_q   <= '0;
`ifdef BHT_GSHARE_EN
            ghr_q        <= '0;
            pred_ghr_q   <= '0;
`endif
        end else begin
            case (state_q)
                BHT_INIT: begin
                    pred_valid_q <= 1'b0;
                    ptr_q        <= ptr_d;
                    if (ptr_q == LAST_IDX) begin
                        state_q <= BHT_RUN;
                        ready_q <= 1'b1;
                    end
                end
                BHT_RUN: begin
                    pred_valid_q <= rd_acc;
                    if (rd_acc) begin
                        pred_ctr_q   <= rd_ctr_d;
                        pred_taken_q <= rd_ctr_d[CTR_W-1];
`ifdef BHT_GSHARE_EN
                        pred_ghr_q   <= ghr_q;
`endif
                    end
`ifdef BHT_GSHARE_EN
                    if (upd_acc) begin
                        ghr_q <= ghr_d;
                    end
`endif
                end
                default: begin
                    state_q <= BHT_INIT;
                end
            endcase
        end
    end

    assign bus.ready      = ready_q;
    assign bus.pred_valid = pred_valid_q;
    assign bus.pred_taken = pred_taken_q;
    assign bus.pred_ctr   = pred_ctr_q;

endmodule

// File: doc/bht_sat_predictor.md
Name: bht_sat_predictor

Overview:
- Parametrised successor of the fixed 32-entry, 2-bit branch history table.
- DEPTH entries of CTR_W-bit saturating counters, indexed by low PC bits.
- One prediction read port with registered output; one update (resolution) port from the execute stage.
- Adds a post-reset init sweep FSM, read-during-write bypass and an optional gshare index hash.
- Sits beside the IF-stage PC logic; updates come from branch resolution in EX.

Parameters:
- DEPTH, 32: number of counter entries; power of 2, range 4..1024.
- IDX_W, $clog2(DEPTH): index width, derived; not to be overridden.
- CTR_W, 2: counter width in bits, range 1..4.
- INIT_CTR, 2**(CTR_W-1)-1: counter value loaded by the init sweep (weakly not-taken).
- GHR_W, IDX_W: global history length; used only with BHT_GSHARE_EN; must be <= IDX_W.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; when 0, reads and updates are ignored and state holds.
- rd_valid  in  1  prediction request this cycle.
- rd_idx  in  IDX_W  PC index bits of the fetched instruction.
- pred_valid  out  1  prediction valid, one cycle after the request.
- pred_taken  out  1  predicted direction (counter MSB).
- pred_ctr  out  CTR_W  raw counter value, for debug and perf.
- upd_valid  in  1  branch resolved this cycle.
- upd_idx  in  IDX_W  index of the resolved branch (previous PC bits).
- upd_taken  in  1  actual outcome.
- ready  out  1  init sweep finished; table usable.

Behaviour:
- Reset: while rst=1 at a clock edge, FSM -> INIT, sweep pointer = 0, pred_valid=0, pred_taken=0, pred_ctr=0, ready=0, GHR=0.
- FSM state INIT:
  - Writes INIT_CTR to entry[ptr] each cycle and increments ptr. Runs regardless of en.
  - After entry DEPTH-1 is written -> RUN; ready=1 from the next cycle.
  - Total: DEPTH cycles from rst deassert to ready=1.
  - rd_valid and upd_valid are ignored; pred_valid stays 0.
  - rst asserted mid-sweep restarts the sweep at ptr=0.
- FSM state RUN: stays until rst. No other transitions.
- Read (RUN, en=1, rd_valid=1):
  - Next cycle: pred_valid=1, pred_ctr=entry[idx], pred_taken=pred_ctr[CTR_W-1].
  - Without a new request, pred_valid=0 and pred_taken/pred_ctr hold their last values.
- Update (RUN, en=1, upd_valid=1): single-cycle read-modify-write of entry[idx].
  - taken: saturating increment; 2**CTR_W-1 stays at 2**CTR_W-1.
  - not-taken: saturating decrement; 0 stays at 0.
  - Saturation is strict; no hysteresis jump.
- Same index read and updated in the same cycle: the prediction returns the post-update value (bypass).
- Back-to-back updates to the same index in consecutive cycles both apply (e.g. 0 -> 1 -> 2).
- Indices are exactly IDX_W wide; there is no out-of-range case and no -1 offset.
- en=0 in RUN: table, GHR and outputs hold; pred_valid=0.

Optional Feature:
- Macro: BHT_GSHARE_EN.
- Defined:
  - GHR_W-bit global history register; on each accepted update, GHR <= {GHR[GHR_W-2:0], upd_taken}.
  - Read index = rd_idx XOR zero-extended GHR.
  - Update index = upd_idx XOR the GHR value captured with that branch's prediction. This value is supplied on an extra input port upd_ghr [GHR_W-1:0].
  - Extra output pred_ghr [GHR_W-1:0] = GHR registered alongside the prediction.
  - The bypass compares the hashed indices.
- Undefined: plain rd_idx/upd_idx indexing; the GHR, upd_ghr and pred_ghr do not exist.

Decomposition:
- Package bht_pkg holds:
  - FSM state enum: BHT_INIT, BHT_RUN.
  - Default CTR_W and DEPTH constants.
  - Function ctr_next(ctr, taken) implementing the saturating counter.
- One sub-module, bht_ctr_update: combinational saturating counter next-state, parametrised by CTR_W. Instantiated once on the update path; the bypass also uses its output.

Test Plan:
- Reset then idle, DEPTH=32, CTR_W=2 -> ready=0 for 32 cycles, then 1. A read of idx 7 returns pred_ctr=1, pred_taken=0.
- Three updates taken on idx 5, then a read -> pred_ctr 1->2->3, pred_taken=1. A fourth taken update keeps 3. Four not-taken updates -> 0, and a further not-taken update keeps 0.
- Same cycle: update taken on idx 9 (ctr=1) and read of idx 9 -> next-cycle pred_ctr=2 (bypass). A read of idx 10 in the same cycle returns 1.
- rst pulsed at sweep cycle 10 after idx 3 had been trained -> ready stays 0 for 32 cycles after deassert; idx 3 reads back 1.
- en=0 with rd_valid=1 and upd_valid=1 on idx 2 -> pred_valid=0; idx 2 unchanged when read later with en=1.
- BHT_GSHARE_EN, GHR_W=5: updates taken, taken, not-taken -> GHR=5'b00110. A read of rd_idx=5'b00011 accesses entry 5'b00101.
